// File: rtl/relu_maxpool2x2_stream.sv
// ReLU + 2x2 stride-2 max pooling over a channel-major raster stream.
// Top-row pair maxima live in a half-width line buffer; one output register with valid/ready.
module relu_maxpool2x2_stream #(
  parameter int DATA_W    = 16,
  parameter int IN_HEIGHT = 4,
  parameter int IN_WIDTH  = 4,
  parameter int CHANNELS  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);

  localparam int CW  = $clog2(IN_WIDTH);
  localparam int RW  = $clog2(IN_HEIGHT);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HW  = IN_WIDTH / 2;
  localparam int LBW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [CHW-1:0] ch;
  logic [LBW-1:0] lb_idx;

  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] linebuf [HW];
  logic signed [DATA_W-1:0] m_pair, m_win, relu;

  logic accept, col_end, row_end, ch_end, win_end;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(IN_WIDTH - 1));
  assign row_end  = (row == RW'(IN_HEIGHT - 1));
  assign ch_end   = (ch == CHW'(CHANNELS - 1));
  assign win_end  = row[0] && col[0];
  assign lb_idx   = LBW'(col >> 1);

  // Pair max feeds both the line buffer (top row) and the window max (bottom row).
  assign m_pair = (in_data > hold) ? in_data : hold;
  assign m_win  = (linebuf[lb_idx] > m_pair) ? linebuf[lb_idx] : m_pair;
  assign relu   = m_win[DATA_W-1] ? '0 : m_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      ch   <= '0;
      hold <= '0;
    end else if (accept) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end) begin
        row <= row_end ? '0 : row + 1'b1;
        if (row_end) ch <= ch_end ? '0 : ch + 1'b1;
      end
      if (!col[0]) hold <= in_data;
    end
  end

  // Always written on a top row before the matching bottom row reads it; no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) linebuf[lb_idx] <= m_pair;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && win_end) begin
      out_valid <= 1'b1;
      out_data  <= relu;
      out_last  <= row_end && col_end && ch_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
